// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-RAM bus between the MEM-stage access unit and data memory.
// Byte-lane strobes assume a 32-bit word (4 lanes).
interface mem_access_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    ram_en;
    logic [3:0]              ram_write_en;
    logic [DATA_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_write_data;
    logic [DATA_WIDTH-1:0]   ram_read_data;
    logic                    ram_ack;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_read_data, ram_ack
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_read_data, ram_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives the RAM bus, stalls the pipeline until
// a load/store completes, aligns/extends load data and flags misalignment and bus timeouts.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic                  mem_sign_ext_flag,
    input  logic [3:0]            mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  reg_write_en,
    input  logic [4:0]            reg_write_addr,
    mem_access_unit_if.master     bus,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  reg_write_en_out,
    output logic [4:0]            reg_write_addr_out,
    output logic                  stall_request,
    output logic                  adel_flag,
    output logic                  ades_flag,
    output logic [DATA_WIDTH-1:0] bad_vaddr,
    output logic                  bus_error_flag
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rd_buf;
    logic                  err_latch;
    logic [DATA_WIDTH-1:0] drain_addr;
    logic [DATA_WIDTH-1:0] drain_wdata;
    logic [3:0]            drain_be;

    logic                  access;
    logic                  is_byte;
    logic                  is_half;
    logic                  misalign;
    logic                  start;
    logic                  timeout;
    logic [3:0]            lane_sel;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_data;

    // Request decode from the EX/MEM fields
    always_comb begin
        access    = mem_read_flag | mem_write_flag;
        is_byte   = (mem_sel == 4'b0001);
        is_half   = (mem_sel == 4'b0011);
        misalign  = (is_half & result[0]) | (!is_byte & !is_half & (result[1:0] != 2'b00));
        lane_sel  = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
        req_be    = mem_write_flag ? 4'(lane_sel << result[1:0]) : 4'b0000;
        req_addr  = {result[DATA_WIDTH-1:2], 2'b00};
        req_wdata = is_byte ? {4{mem_write_data[7:0]}} :
                    (is_half ? {2{mem_write_data[15:0]}} : mem_write_data);
        start     = (state == IDLE) & access & !misalign & !flush;
        timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Load alignment and extension from the read buffer
    always_comb begin
        shifted   = rd_buf >> {result[1:0], 3'b000};
        load_data = shifted;
        if (is_byte) begin
            load_data = {{(DATA_WIDTH-8){mem_sign_ext_flag & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            load_data = {{(DATA_WIDTH-16){mem_sign_ext_flag & shifted[15]}}, shifted[15:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_buf      <= '0;
            err_latch   <= 1'b0;
            drain_addr  <= '0;
            drain_wdata <= '0;
            drain_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    err_latch <= 1'b0;
                    if (start) begin
                        if (bus.ram_ack) begin
                            state <= DONE;
                            if (mem_read_flag) rd_buf <= bus.ram_read_data;
                        end else begin
                            state       <= WAIT;
                            cnt         <= CNT_W'(1);
                            drain_addr  <= req_addr;
                            drain_wdata <= req_wdata;
                            drain_be    <= req_be;
                        end
                    end
                end
                WAIT: begin
                    if (bus.ram_ack) begin
                        // A flushed access still completes on the bus, its data is dropped
                        state <= flush ? IDLE : DONE;
                        if (!flush && mem_read_flag) rd_buf <= bus.ram_read_data;
                    end else if (timeout) begin
                        state     <= flush ? IDLE : DONE;
                        err_latch <= !flush;
                    end else begin
                        state <= flush ? DRAIN : WAIT;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    err_latch <= 1'b0;
                end
                DRAIN: begin
                    if (bus.ram_ack || timeout) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and pipeline outputs decoded from state and current inputs
    always_comb begin
        bus.ram_en         = 1'b0;
        bus.ram_write_en   = 4'b0000;
        bus.ram_addr       = '0;
        bus.ram_write_data = '0;
        result_out         = result;
        reg_write_en_out   = reg_write_en;
        reg_write_addr_out = reg_write_addr;
        stall_request      = 1'b0;
        adel_flag          = 1'b0;
        ades_flag          = 1'b0;
        bad_vaddr          = '0;
        bus_error_flag     = 1'b0;
        if (rst) begin
            result_out         = '0;
            reg_write_en_out   = 1'b0;
            reg_write_addr_out = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        reg_write_en_out = 1'b0;
                    end else if (access && misalign) begin
                        adel_flag        = mem_read_flag;
                        ades_flag        = mem_write_flag & !mem_read_flag;
                        bad_vaddr        = result;
                        reg_write_en_out = 1'b0;
                    end else if (access) begin
                        bus.ram_en         = 1'b1;
                        bus.ram_write_en   = req_be;
                        bus.ram_addr       = req_addr;
                        bus.ram_write_data = req_wdata;
                        stall_request      = 1'b1;
                        reg_write_en_out   = 1'b0;
                    end
                end
                WAIT: begin
                    bus.ram_en         = 1'b1;
                    bus.ram_write_en   = req_be;
                    bus.ram_addr       = req_addr;
                    bus.ram_write_data = req_wdata;
                    stall_request      = 1'b1;
                    reg_write_en_out   = 1'b0;
                end
                DONE: begin
                    if (flush) begin
                        reg_write_en_out = 1'b0;
                    end else if (err_latch) begin
                        bus_error_flag   = 1'b1;
                        result_out       = '0;
                        reg_write_en_out = 1'b0;
                        bad_vaddr        = result;
                    end else if (mem_read_flag) begin
                        result_out = load_data;
                    end
                end
                DRAIN: begin
                    bus.ram_en         = 1'b1;
                    bus.ram_write_en   = drain_be;
                    bus.ram_addr       = drain_addr;
                    bus.ram_write_data = drain_wdata;
                    if (access) begin
                        stall_request    = 1'b1;
                        reg_write_en_out = 1'b0;
                    end
                    if (flush) reg_write_en_out = 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboarded load/store transactions plus
// directed misalignment, timeout, flush/drain and reset cases.
module tb_mem_access_unit;
    localparam int unsigned TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] result;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic        stall_request;
    logic        adel_flag;
    logic        ades_flag;
    logic [31:0] bad_vaddr;
    logic        bus_error_flag;

    mem_access_unit_if #(.DATA_WIDTH(32)) bus ();

    mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .mem_read_flag      (mem_read_flag),
        .mem_write_flag     (mem_write_flag),
        .mem_sign_ext_flag  (mem_sign_ext_flag),
        .mem_sel            (mem_sel),
        .mem_write_data     (mem_write_data),
        .result             (result),
        .reg_write_en       (reg_write_en),
        .reg_write_addr     (reg_write_addr),
        .bus                (bus),
        .result_out         (result_out),
        .reg_write_en_out   (reg_write_en_out),
        .reg_write_addr_out (reg_write_addr_out),
        .stall_request      (stall_request),
        .adel_flag          (adel_flag),
        .ades_flag          (ades_flag),
        .bad_vaddr          (bad_vaddr),
        .bus_error_flag     (bus_error_flag)
    );

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic        berr;
        logic [31:0] vaddr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush             = 1'b0;
        mem_read_flag     = 1'b0;
        mem_write_flag    = 1'b0;
        mem_sign_ext_flag = 1'b0;
        mem_sel           = 4'b1111;
        mem_write_data    = 32'h0;
        result            = 32'h0;
        reg_write_en      = 1'b0;
        reg_write_addr    = 5'd0;
        bus.ram_ack       = 1'b0;
        bus.ram_read_data = 32'h0;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [3:0] sel, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        if (sel == 4'b0001) return sext ? {{24{b[7]}}, b} : {24'h0, b};
        if (sel == 4'b0011) return sext ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] sel, input logic [31:0] a);
        if (sel == 4'b0001) return 4'b0001 << a[1:0];
        if (sel == 4'b0011) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] sel, input logic [31:0] d);
        if (sel == 4'b0001) return {4{d[7:0]}};
        if (sel == 4'b0011) return {2{d[15:0]}};
        return d;
    endfunction

    // One aligned load (rd=1) or store (rd=0); ack_at<0 means the bus never acknowledges
    task automatic do_access(input string tag, input logic rd, input logic sext,
                             input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wd, input int ack_at,
                             input logic [31:0] rdata);
        exp_t e;
        exp_t got;
        int   stalls;
        bit   done;
        int   exp_stalls;
        mem_read_flag     = rd;
        mem_write_flag    = !rd;
        mem_sign_ext_flag = sext;
        mem_sel           = sel;
        result            = addr;
        mem_write_data    = wd;
        reg_write_en      = rd;
        reg_write_addr    = addr[6:2];
        flush             = 1'b0;
        e.berr  = (ack_at < 0);
        e.res   = e.berr ? 32'h0 : (rd ? model_load(rdata, addr, sel, sext) : addr);
        e.we    = rd & !e.berr;
        e.vaddr = e.berr ? addr : 32'h0;
        sb.push_back(e);
        exp_stalls = e.berr ? int'(TIMEOUT) : ack_at + 1;
        stalls = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            bus.ram_ack       = (cyc == ack_at);
            bus.ram_read_data = (cyc == ack_at) ? rdata : $urandom;
            @(negedge clk);
            if (stall_request) begin
                stalls++;
                if (cyc == 0) begin
                    check({tag, "_ram_en"}, 32'(bus.ram_en), 32'd1);
                    check({tag, "_addr"}, bus.ram_addr, {addr[31:2], 2'b00});
                    check({tag, "_be"}, 32'(bus.ram_write_en), rd ? 32'd0 : 32'(model_be(sel, addr)));
                    if (!rd) check({tag, "_wdata"}, bus.ram_write_data, model_wdata(sel, wd));
                end
            end else begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    check({tag, "_result"}, result_out, got.res);
                    check({tag, "_we"}, 32'(reg_write_en_out), 32'(got.we));
                    check({tag, "_berr"}, 32'(bus_error_flag), 32'(got.berr));
                    check({tag, "_vaddr"}, bad_vaddr, got.vaddr);
                    check({tag, "_waddr"}, 32'(reg_write_addr_out), 32'(addr[6:2]));
                    check({tag, "_done_en"}, 32'(bus.ram_en), 32'd0);
                end
            end
            next_cycle();
        end
        bus.ram_ack = 1'b0;
        if (!done) check({tag, "_no_done"}, 32'd0, 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Outputs must stay zero under reset even with an access presented
        mem_read_flag  = 1'b1;
        result         = 32'h100;
        reg_write_en   = 1'b1;
        reg_write_addr = 5'd5;
        @(negedge clk);
        @(negedge clk);
        check("rst_ram_en", 32'(bus.ram_en), 32'd0);
        check("rst_stall", 32'(stall_request), 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_we", 32'(reg_write_en_out), 32'd0);
        check("rst_waddr", 32'(reg_write_addr_out), 32'd0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        do_access("lw",  1'b1, 1'b0, 4'b1111, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        do_access("lb",  1'b1, 1'b1, 4'b0001, 32'h103, 32'h0, 0, 32'h80112233);
        do_access("lbu", 1'b1, 1'b0, 4'b0001, 32'h103, 32'h0, 0, 32'h80112233);
        do_access("lh",  1'b1, 1'b1, 4'b0011, 32'h102, 32'h0, 1, 32'h80112233);
        do_access("lhu", 1'b1, 1'b0, 4'b0011, 32'h100, 32'h0, 2, 32'h8011A233);
        do_access("sh",  1'b0, 1'b0, 4'b0011, 32'h202, 32'h1234ABCD, 1, 32'h0);
        do_access("sb",  1'b0, 1'b0, 4'b0001, 32'h101, 32'h000000AB, 0, 32'h0);
        do_access("sw",  1'b0, 1'b0, 4'b1111, 32'h204, 32'hCAFEF00D, 2, 32'h0);
        do_access("tmo", 1'b1, 1'b0, 4'b1111, 32'h180, 32'h0, -1, 32'h0);
        do_access("lw2", 1'b1, 1'b0, 4'b1111, 32'h184, 32'h0, 0, 32'h13579BDF);

        // Misaligned load and store: flag, no request, no stall
        mem_read_flag = 1'b1; mem_sel = 4'b1111; result = 32'h102; reg_write_en = 1'b1;
        @(negedge clk);
        check("adel", 32'(adel_flag), 32'd1);
        check("adel_ades", 32'(ades_flag), 32'd0);
        check("adel_vaddr", bad_vaddr, 32'h102);
        check("adel_ram_en", 32'(bus.ram_en), 32'd0);
        check("adel_stall", 32'(stall_request), 32'd0);
        check("adel_we", 32'(reg_write_en_out), 32'd0);
        next_cycle();
        idle_inputs();
        mem_write_flag = 1'b1; mem_sel = 4'b1111; result = 32'h101;
        @(negedge clk);
        check("ades", 32'(ades_flag), 32'd1);
        check("ades_vaddr", bad_vaddr, 32'h101);
        check("ades_ram_en", 32'(bus.ram_en), 32'd0);
        next_cycle();

        // Flush in IDLE suppresses request and flags
        idle_inputs();
        mem_read_flag = 1'b1; mem_sel = 4'b1111; result = 32'h102; reg_write_en = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_adel", 32'(adel_flag), 32'd0);
        check("flush_we", 32'(reg_write_en_out), 32'd0);
        next_cycle();
        result = 32'h100;
        @(negedge clk);
        check("flush_ram_en", 32'(bus.ram_en), 32'd0);
        check("flush_stall", 32'(stall_request), 32'd0);
        next_cycle();

        // Non-access pass-through
        idle_inputs();
        result = 32'h55; reg_write_en = 1'b1; reg_write_addr = 5'd9;
        @(negedge clk);
        check("pass_result", result_out, 32'h55);
        check("pass_we", 32'(reg_write_en_out), 32'd1);
        check("pass_waddr", 32'(reg_write_addr_out), 32'd9);
        check("pass_stall", 32'(stall_request), 32'd0);
        next_cycle();

        // Store flushed in WAIT keeps its request on the bus through DRAIN
        idle_inputs();
        mem_write_flag = 1'b1; mem_sel = 4'b1111; result = 32'h300; mem_write_data = 32'h11223344;
        @(negedge clk);
        check("drain_start_stall", 32'(stall_request), 32'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("drain_wait_en", 32'(bus.ram_en), 32'd1);
        next_cycle();
        idle_inputs();
        result = 32'h999; reg_write_en = 1'b1;
        @(negedge clk);
        check("drain_en", 32'(bus.ram_en), 32'd1);
        check("drain_be", 32'(bus.ram_write_en), 32'hF);
        check("drain_addr", bus.ram_addr, 32'h300);
        check("drain_wdata", bus.ram_write_data, 32'h11223344);
        check("drain_stall", 32'(stall_request), 32'd0);
        check("drain_pass", result_out, 32'h999);
        check("drain_pass_we", 32'(reg_write_en_out), 32'd1);
        next_cycle();
        mem_read_flag = 1'b1; mem_sel = 4'b1111; result = 32'h400; reg_write_en = 1'b1;
        bus.ram_ack = 1'b1; bus.ram_read_data = 32'hCAFE0000;
        @(negedge clk);
        check("drain_new_stall", 32'(stall_request), 32'd1);
        check("drain_new_addr", bus.ram_addr, 32'h300);
        check("drain_new_we", 32'(reg_write_en_out), 32'd0);
        next_cycle();
        bus.ram_ack = 1'b0;
        do_access("after_drain", 1'b1, 1'b0, 4'b1111, 32'h400, 32'h0, 0, 32'h0BADF00D);

        // Async reset while waiting drops the request immediately
        mem_read_flag = 1'b1; mem_sel = 4'b1111; result = 32'h500; reg_write_en = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("rst_wait_en", 32'(bus.ram_en), 32'd0);
        check("rst_wait_stall", 32'(stall_request), 32'd0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        do_access("post_rst", 1'b1, 1'b1, 4'b0011, 32'h506, 32'h0, 1, 32'h7FFF0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access unit sitting directly downstream of the EX/MEM pipeline register; consumes its memory-control, address/result and write-back fields and feeds the MEM/WB register. Drives a request/acknowledge data-RAM bus with byte lanes, holds the pipeline via stall_request until a load/store completes, aligns and extends load data, and flags misaligned accesses and bus timeouts.

Parameters:
DATA_WIDTH, 32, data/address word width (fixed 32 in this design; byte-lane logic assumes 4 lanes)
TIMEOUT_CYCLES, 64, maximum WAIT/DRAIN cycles without ram_ack before bus error (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  exception/eret flush from control unit
mem_read_flag  in  1  load in MEM stage
mem_write_flag  in  1  store in MEM stage
mem_sign_ext_flag  in  1  1 = sign-extend load, 0 = zero-extend
mem_sel  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word, other values treated as word
mem_write_data  in  32  store data, right-justified
result  in  32  ALU result; effective address for loads/stores
reg_write_en  in  1  write-back enable from EX/MEM
reg_write_addr  in  5  write-back register
ram_en  out  1  bus request
ram_write_en  out  4  byte-lane write strobes (0 for loads)
ram_addr  out  32  word address, {result[31:2],2'b00}
ram_write_data  out  32  lane-replicated store data
ram_read_data  in  32  read data, valid with ram_ack
ram_ack  in  1  bus acknowledge, sampled at rising edge
result_out  out  32  load data (extended) or pass-through result
reg_write_en_out  out  1  write-back enable to MEM/WB
reg_write_addr_out  out  5  write-back register to MEM/WB
stall_request  out  1  holds EX/MEM and earlier stages
adel_flag  out  1  load address error
ades_flag  out  1  store address error
bad_vaddr  out  32  faulting address (= result when adel/ades/bus_error)
bus_error_flag  out  1  ack timeout occurred for this access

Behaviour:
- access = mem_read_flag | mem_write_flag. Misalign: half with result[0]=1; word with result[1:0]!=0. Misaligned load -> adel_flag=1; store -> ades_flag=1; no bus request, no stall, reg_write_en_out=0.
- FSM states IDLE, WAIT, DONE, DRAIN. Reset (async): state IDLE, read buffer 0, timeout counter 0, error latch 0; all outputs 0 while rst=1.
- IDLE: aligned access and !flush -> ram_en=1 combinationally, stall_request=1; next state DONE if ram_ack sampled 1 this edge, else WAIT.
- WAIT: ram_en=1, bus fields from current inputs (EX/MEM held by stall), stall_request=1; counter increments; ram_ack -> DONE; counter reaches TIMEOUT_CYCLES-1 without ack -> DONE with error latch set.
- DONE: ram_en=0, stall_request=0; result_out from read buffer; next edge -> IDLE unconditionally. Minimum access therefore 2 MEM cycles (one stall cycle).
- Read buffer captures ram_read_data at the acking edge for loads only.
- Load align: shifted = buffer >> 8*result[1:0]; byte ext from bit 7, half from bit 15, word as-is; extension per mem_sign_ext_flag.
- Store: ram_write_en = mem_sel << result[1:0]; ram_write_data = byte x4, half x2, or word.
- Non-access or flush-cancelled instructions: result_out=result, reg_write_en_out=reg_write_en, no stall. reg_write_addr_out always = reg_write_addr.
- Bus error in DONE: bus_error_flag=1 one cycle, result_out=0, reg_write_en_out=0, bad_vaddr=result.
- flush in IDLE/DONE: IDLE, suppress flags/reg_write_en_out that cycle. flush in WAIT: -> DRAIN (request already on bus cannot be withdrawn).
- DRAIN: ram_en=1 with captured addr/strobes/data (latched on WAIT entry); stall_request=0 unless a new access is present, then 1; ack or timeout -> IDLE, data discarded, no flags.
- Simultaneous ram_ack and flush in WAIT: transaction completed, go IDLE, data discarded.

Test Plan:
- LW addr 0x100, ack after 3 cycles with 0xDEADBEEF -> stall_request high 4 cycles, DONE result_out=0xDEADBEEF, reg_write_en_out=1.
- LB signed addr 0x103, ram_read_data 0x80112233, same-cycle ack -> one stall cycle, result_out=0xFFFFFF80; LBU -> 0x00000080.
- SH 0x1234ABCD to 0x202 -> ram_write_en=4'b1100, ram_write_data=0xABCDABCD, ram_addr=0x200.
- LW addr 0x102 -> adel_flag=1, bad_vaddr=0x102, ram_en=0, no stall; SW 0x101 -> ades_flag=1.
- LW with ack never asserted, TIMEOUT_CYCLES=8 -> stall 8 cycles, bus_error_flag pulse, reg_write_en_out=0, result_out=0.
- SW in WAIT, flush asserted, ack 2 cycles later -> ram_en held through DRAIN with original strobes, stall_request=0, rst mid-WAIT -> ram_en=0 immediately.
